// File: rtl/serial_slave_port.sv
// serial_slave_port
//   Slave-side endpoint of the serial system bus. Terminates one arbiter
//   slave channel and bridges it to a single-port synchronous memory or
//   register bank. Address and write data arrive MSB first on wr_bus. Read
//   data is returned MSB first on rd_bus. Both directions use a valid/ready
//   handshake, and a bit moves only on a clock edge where both are high.
//
//   Frame format (master -> slave): ADDR_WIDTH address bits, then, for
//   writes only, DATA_WIDTH data bits. mode is sampled with the first
//   address bit only (1 = write, 0 = read).
//
// Ports
//   clk, rst         clock (rising edge) and synchronous active-high reset
//   mode             frame direction, sampled with the first address bit
//   wr_bus           serial master->slave bit
//   master_valid     wr_bus bit valid
//   slave_ready      slave accepts wr_bus bit
//   rd_bus           serial slave->master read bit
//   slave_valid      rd_bus bit valid
//   master_ready     master accepts rd_bus bit
//   mem_addr         registered memory address
//   mem_wdata        registered memory write data
//   mem_we, mem_re   one-cycle write / read strobes
//   mem_rdata        memory read data, valid READ_LATENCY cycles after mem_re
//   timeout_err      one-cycle stall-abort pulse
//
// Build option
//   SSP_TIMEOUT_EN   When defined, a stall counter aborts a frame that makes
//                    no progress for TIMEOUT_CYCLES cycles in RX_ADDR, RX_DATA
//                    or TX_DATA. When undefined, timeout_err is tied 0 and the
//                    block waits indefinitely.
module serial_slave_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  output logic                  rd_bus,
  output logic                  slave_valid,
  input  logic                  master_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    MEM_WR,
    MEM_RD,
    RD_WAIT,
    TX_DATA
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_shift;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] tx_shift;

  logic                  ready_int;
  logic                  valid_int;
  logic                  rx_beat;
  logic                  tx_beat;
  logic                  timeout_hit;
  logic                  addr_last;
  logic                  data_last;
  logic                  wait_last;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;

  // ---------------------------------------------------------------------
  // Handshake and frame-position decode
  // ---------------------------------------------------------------------
  // The timeout cycle withdraws ready/valid so no beat can land in the
  // same cycle the frame is being abandoned.
  assign ready_int = ((state == IDLE) || (state == RX_ADDR) || (state == RX_DATA))
                     && !timeout_hit;
  assign valid_int = (state == TX_DATA) && !timeout_hit;

  assign rx_beat = master_valid && ready_int;
  assign tx_beat = valid_int && master_ready;

  // The first address bit starts a fresh shift value, so stale bits from
  // the previous frame never leak into a short address.
  assign addr_in = (state == IDLE) ? ADDR_WIDTH'(wr_bus)
                                   : ((addr_shift << 1) | ADDR_WIDTH'(wr_bus));
  assign data_in = (data_shift << 1) | DATA_WIDTH'(wr_bus);

  assign addr_last = ((state == IDLE) && (ADDR_WIDTH == 1)) ||
                     ((state == RX_ADDR) && (cnt == CNT_W'(ADDR_WIDTH - 1)));
  assign data_last = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign wait_last = (cnt == CNT_W'(READ_LATENCY - 1));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_beat) begin
          if (ADDR_WIDTH == 1) begin
            state_nxt = mode ? RX_DATA : MEM_RD;
          end else begin
            state_nxt = RX_ADDR;
          end
        end
      end
      RX_ADDR: begin
        if (rx_beat && addr_last) begin
          state_nxt = mode_q ? RX_DATA : MEM_RD;
        end
      end
      RX_DATA: begin
        if (rx_beat && data_last) begin
          state_nxt = MEM_WR;
        end
      end
      MEM_WR:  state_nxt = IDLE;
      MEM_RD:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (wait_last) begin
          state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_beat && data_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // State, bit counter and shift registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      addr_shift <= '0;
      addr_q     <= '0;
      data_shift <= '0;
      wdata_q    <= '0;
      tx_shift   <= '0;
    end else begin
      state <= state_nxt;

      // The counter restarts on every state change. Leaving IDLE has
      // already consumed the address MSB, so it resumes from 1.
      if (state_nxt != state) begin
        cnt <= ((state == IDLE) && (state_nxt == RX_ADDR)) ? CNT_W'(1) : '0;
      end else if ((rx_beat && (state != IDLE)) || tx_beat || (state == RD_WAIT)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (rx_beat && (state == IDLE)) begin
        mode_q <= mode;
      end

      if (rx_beat && ((state == IDLE) || (state == RX_ADDR))) begin
        addr_shift <= addr_in;
        if (addr_last) begin
          addr_q <= addr_in;
        end
      end

      if (rx_beat && (state == RX_DATA)) begin
        data_shift <= data_in;
        if (data_last) begin
          wdata_q <= data_in;
        end
      end

      // mem_rdata is valid in the last RD_WAIT cycle; it is captured on
      // the edge that enters TX_DATA.
      if ((state == RD_WAIT) && wait_last) begin
        tx_shift <= mem_rdata;
      end else if (tx_beat) begin
        tx_shift <= tx_shift << 1;
      end
    end
  end

`ifdef SSP_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_state;

  assign stall_state = (state == RX_ADDR) || (state == RX_DATA) || (state == TX_DATA);
  assign timeout_hit = stall_state && (stall_cnt == STALL_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!stall_state || (state_nxt != state) || rx_beat || tx_beat) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs, forced low while reset is held
  // ---------------------------------------------------------------------
  assign slave_ready = ready_int && !rst;
  assign slave_valid = valid_int && !rst;
  assign rd_bus      = valid_int && !rst && tx_shift[DATA_WIDTH-1];
  assign mem_addr    = rst ? '0 : addr_q;
  assign mem_wdata   = rst ? '0 : wdata_q;
  assign mem_we      = (state == MEM_WR) && !rst;
  assign mem_re      = (state == MEM_RD) && !rst;
  assign timeout_err = timeout_hit && !rst;

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial system bus. It terminates one arbiter slave channel (sN_* signals) and bridges it to a single-port synchronous memory or register bank.
- Deserialises the address and write data from wr_bus and serialises read data onto rd_bus.
- Uses the bus valid/ready handshake in both directions.
- One instance sits behind each arbiter slave port (S1/S2/S3).

Parameters:
ADDR_WIDTH, 12, address bits per frame, sent MSB first
DATA_WIDTH, 8, data bits per frame, sent MSB first
READ_LATENCY, 2, cycles from mem_re to valid mem_rdata (1..4)
TIMEOUT_CYCLES, 64, stall limit in cycles; used only with SSP_TIMEOUT_EN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  1  1=write, 0=read; sampled with first address bit only
wr_bus  in  1  serial master->slave bit
master_valid  in  1  wr_bus bit valid
slave_ready  out  1  slave accepts wr_bus bit
rd_bus  out  1  serial slave->master read bit
slave_valid  out  1  rd_bus bit valid
master_ready  in  1  master accepts rd_bus bit
mem_addr  out  ADDR_WIDTH  memory address (registered)
mem_wdata  out  DATA_WIDTH  memory write data (registered)
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  DATA_WIDTH  memory read data
timeout_err  out  1  one-cycle stall-abort pulse (tied 0 without SSP_TIMEOUT_EN)

Behaviour:
- Reset: while rst=1, every output is 0, including slave_ready. The state becomes IDLE and the counter, shift registers, mem_addr and mem_wdata clear. In the first cycle after reset, slave_ready=1.
- Rx beat: a bit transfers when master_valid && slave_ready are both high at a clock edge. If master_valid is low, nothing is consumed, with no limit on the length of the gap.
- Tx beat: a bit transfers when slave_valid && master_ready are both high at a clock edge. While master_ready is low, rd_bus and slave_valid hold steady.
- Bit counter: width is $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). It clears on every state change.
- States:
  - IDLE: slave_ready=1. On an rx beat, latch mode, shift in address MSB, set count=1, then go to RX_ADDR. If ADDR_WIDTH=1, go straight to the post-address state instead.
  - RX_ADDR: slave_ready=1. Each beat shifts wr_bus into the address LSB. On the beat that completes ADDR_WIDTH bits, mem_addr takes the full address; go to RX_DATA (write) or MEM_RD (read).
  - RX_DATA: slave_ready=1. Shift DATA_WIDTH bits. On the final beat, mem_wdata takes the word; go to MEM_WR.
  - MEM_WR: slave_ready=0, mem_we=1 for exactly one cycle, then go to IDLE.
  - MEM_RD: slave_ready=0, mem_re=1 for exactly one cycle, then go to RD_WAIT.
  - RD_WAIT: wait READ_LATENCY-1 cycles, then capture mem_rdata into the tx shift register and go to TX_DATA. slave_valid therefore rises READ_LATENCY+1 cycles after the final address beat.
  - TX_DATA: slave_valid=1, rd_bus = tx_shift MSB. Each tx beat shifts left. After DATA_WIDTH beats, go to IDLE with slave_valid=0 in that cycle.
- slave_ready is 0 in every state except IDLE, RX_ADDR and RX_DATA.
- mem_we and mem_re are never high together, and each is high for at most one cycle per frame.
- Master holding master_valid high outside rx states: ignored, no bits consumed.
- Master asserting master_ready outside TX_DATA: ignored.
- Reset in any state (including mid-frame, MEM_WR or TX_DATA): abort immediately. No pending mem_we or mem_re is issued.
- Back-to-back frames: the first address bit of the next frame can be accepted in the first IDLE cycle after MEM_WR or after the last tx beat.

Optional Feature:
- SSP_TIMEOUT_EN defined:
  - A stall counter runs in RX_ADDR, RX_DATA and TX_DATA. It resets on every rx/tx beat and on every state entry.
  - When it reaches TIMEOUT_CYCLES, the block pulses timeout_err for one cycle and returns to IDLE. No memory strobe is issued.
  - This recovers from the arbiter dropping a connection mid-frame.
- SSP_TIMEOUT_EN undefined: no stall counter, timeout_err tied 0, and the block waits indefinitely.

Test Plan:
(All tests use ADDR_WIDTH=12, DATA_WIDTH=8, READ_LATENCY=2.)
- Write, addr 0x0A5, data 0x3C, 20 consecutive beats with mode=1 -> one mem_we pulse with mem_addr=0x0A5 and mem_wdata=0x3C the cycle after the final beat; slave_ready returns high one cycle later; mem_re stays 0.
- Read, addr 0x0A5, memory model returns 0x3C at latency 2 -> single mem_re pulse; slave_valid rises 3 cycles after the final address beat; rd_bus sequence 0,0,1,1,1,1,0,0 with master_ready=1.
- Read with master_ready low for 3 cycles after the 4th tx bit -> rd_bus holds 1 and slave_valid stays 1 throughout; total 8 bits delivered, no duplicates.
- Write with master_valid low for 5 cycles after the 6th address bit, and mode toggled during the gap -> still 12 address bits total, captured address 0x0A5, frame treated as write.
- Reset pulse after the 3rd data bit of a write -> all outputs 0 during reset; mem_we never asserted; a following write of 0x001/0xFF completes correctly.
- SSP_TIMEOUT_EN, TIMEOUT_CYCLES=16, master stops after 4 address bits -> timeout_err high for one cycle, 16 cycles after the last beat; IDLE with slave_ready=1 next cycle; no mem strobes.
